// File: rtl/cpu16_regdbg.sv
// Debug-side initiator for the cpu16 register file: single register read/write
// and full dump, with results returned on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for a command; ports released to the CPU
// RADDR | read address presented on rf_asel
// RCAP  | rf_adata valid; result captured
// OUT   | result offered on out_*; waits for out_ready
// WR    | single-cycle write strobe
// WGAP  | guard cycle so no read lands next to the write
module cpu16_regdbg #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_halted,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_reg,
  input  logic [DW-1:0] cmd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          dbg_active,
  output logic [AW-1:0] rf_asel,
  input  logic [DW-1:0] rf_adata,
  output logic [AW-1:0] rf_wsel,
  output logic          rf_wreg,
  output logic [DW-1:0] rf_wdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RCAP  = 3'd2,
    S_OUT   = 3'd3,
    S_WR    = 3'd4,
    S_WGAP  = 3'd5
  } state_t;

  localparam logic [1:0]    OP_READ  = 2'd0;
  localparam logic [1:0]    OP_WRITE = 2'd1;
  localparam logic [1:0]    OP_DUMP  = 2'd2;
  localparam logic [AW-1:0] IDX_MAX  = '1;

  state_t        state, state_nxt;
  logic [1:0]    op_q, op_nxt;
  logic [AW-1:0] idx_q, idx_nxt;
  logic          accept;
  logic          xfer;

  logic [AW-1:0] rf_asel_nxt;
  logic [AW-1:0] rf_wsel_nxt;
  logic          rf_wreg_nxt;
  logic [DW-1:0] rf_wdata_nxt;
  logic          out_valid_nxt;
  logic [DW-1:0] out_data_nxt;
  logic [AW-1:0] out_idx_nxt;
  logic          out_last_nxt;

  assign cmd_ready  = (state == S_IDLE) && cpu_halted;
  assign dbg_active = (state != S_IDLE);
  assign accept     = cmd_ready && cmd_valid;
  assign xfer       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      idx_q     <= '0;
      rf_asel   <= '0;
      rf_wsel   <= '0;
      rf_wreg   <= 1'b0;
      rf_wdata  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      idx_q     <= idx_nxt;
      rf_asel   <= rf_asel_nxt;
      rf_wsel   <= rf_wsel_nxt;
      rf_wreg   <= rf_wreg_nxt;
      rf_wdata  <= rf_wdata_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_idx   <= out_idx_nxt;
      out_last  <= out_last_nxt;
    end
  end

  // Reserved op 3 is accepted but leaves the FSM in IDLE.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    idx_nxt   = idx_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          op_nxt = cmd_op;
          case (cmd_op)
            OP_READ: begin
              state_nxt = S_RADDR;
              idx_nxt   = cmd_reg;
            end
            OP_WRITE: begin
              state_nxt = S_WR;
              idx_nxt   = cmd_reg;
            end
            OP_DUMP: begin
              state_nxt = S_RADDR;
              idx_nxt   = '0;
            end
            default: state_nxt = S_IDLE;
          endcase
        end
      end
      S_RADDR: state_nxt = S_RCAP;
      S_RCAP:  state_nxt = S_OUT;
      S_OUT: begin
        if (xfer) begin
          if (out_last) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_RADDR;
            idx_nxt   = idx_q + AW'(1);
          end
        end
      end
      S_WR:    state_nxt = S_WGAP;
      S_WGAP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    rf_asel_nxt   = rf_asel;
    rf_wsel_nxt   = rf_wsel;
    rf_wdata_nxt  = rf_wdata;
    rf_wreg_nxt   = (state_nxt == S_WR);
    out_valid_nxt = (state_nxt == S_OUT);
    out_data_nxt  = out_data;
    out_idx_nxt   = out_idx;
    out_last_nxt  = out_last;

    if (state_nxt == S_RADDR) begin
      rf_asel_nxt = idx_nxt;
    end
    if (state == S_IDLE && state_nxt == S_WR) begin
      rf_wsel_nxt  = idx_nxt;
      rf_wdata_nxt = cmd_data;
    end
    if (state == S_RCAP) begin
      out_data_nxt = rf_adata;
      out_idx_nxt  = idx_q;
      out_last_nxt = (op_q == OP_READ) || (idx_q == IDX_MAX);
    end
  end

endmodule

// File: tb/tb_cpu16_regdbg.sv
// Self-checking bench for cpu16_regdbg with a behavioural 8x16 register file
// and a scoreboard of expected read results.
module tb_cpu16_regdbg;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_halted;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_reg;
  logic [DW-1:0] cmd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;
  logic          dbg_active;
  logic [AW-1:0] rf_asel;
  logic [DW-1:0] rf_adata;
  logic [AW-1:0] rf_wsel;
  logic          rf_wreg;
  logic [DW-1:0] rf_wdata;

  cpu16_regdbg #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_halted(cpu_halted),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .dbg_active(dbg_active),
    .rf_asel(rf_asel), .rf_adata(rf_adata), .rf_wsel(rf_wsel),
    .rf_wreg(rf_wreg), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rf_mem [8];
  always @(posedge clk) begin
    if (rf_wreg) rf_mem[rf_wsel] <= rf_wdata;
    rf_adata <= rf_mem[rf_asel];
  end

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] rsel;
    logic [DW-1:0] data;
    logic          exp_out;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_xfer = -1;
  logic chk_spacing = 1'b0;
  logic found;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [AW-1:0] i, input logic l);
    exp_t e;
    e.data = d;
    e.idx  = i;
    e.last = l;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_out: got idx %0d data %0h, expected no result", out_idx, out_data);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(mon_e.data));
        check("out_idx", 32'(out_idx), 32'(mon_e.idx));
        check("out_last", 32'(out_last), 32'(mon_e.last));
        if (chk_spacing && last_xfer >= 0) check("dump_spacing", 32'(cyc - last_xfer), 32'd3);
        last_xfer = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller one step after the accepting edge (cycle 1).
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] r, input logic [DW-1:0] d);
    logic ok;
    ok = 1'b0;
    cmd_op = op;
    cmd_reg = r;
    cmd_data = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!dbg_active && sb.size() == 0) ok = 1'b1;
      tick();
    end
    if (!ok) check("idle_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Returns at the negedge where the requested result is offered.
  task automatic wait_out(input logic [AW-1:0] idx, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_idx == idx) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("wait_out_timeout", 32'(idx), 32'hFFFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd1, 3'd5, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{2'd0, 3'd5, 16'h0000, 1'b1, 16'hBEEF};
    vecs[2] = '{2'd1, 3'd0, 16'h0001, 1'b0, 16'h0000};
    vecs[3] = '{2'd1, 3'd7, 16'hFFFF, 1'b0, 16'h0000};
    vecs[4] = '{2'd0, 3'd0, 16'h0000, 1'b1, 16'h0001};
    vecs[5] = '{2'd0, 3'd7, 16'h0000, 1'b1, 16'hFFFF};
    vecs[6] = '{2'd3, 3'd5, 16'h1234, 1'b0, 16'h0000};
    vecs[7] = '{2'd0, 3'd5, 16'h0000, 1'b1, 16'hBEEF};
    vecs[8] = '{2'd1, 3'd5, 16'h0000, 1'b0, 16'h0000};
    vecs[9] = '{2'd0, 3'd5, 16'h0000, 1'b1, 16'h0000};

    reset_n = 1'b0;
    cpu_halted = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_reg = '0;
    cmd_data = '0;
    out_ready = 1'b1;

    tick();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rf_wreg", 32'(rf_wreg), 32'd0);
    check("rst_dbg_active", 32'(dbg_active), 32'd0);
    check("rst_rf_asel", 32'(rf_asel), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();

    // Write timing: one-cycle strobe, ready again three cycles after accept.
    issue(2'd1, 3'd5, 16'hBEEF);
    @(negedge clk);
    check("wr_strobe", 32'(rf_wreg), 32'd1);
    check("wr_sel", 32'(rf_wsel), 32'd5);
    check("wr_data", 32'(rf_wdata), 32'hBEEF);
    check("wr_busy1", 32'(cmd_ready), 32'd0);
    check("wr_active", 32'(dbg_active), 32'd1);
    tick();
    @(negedge clk);
    check("wr_strobe_off", 32'(rf_wreg), 32'd0);
    check("wr_busy2", 32'(cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    check("wr_ready_again", 32'(cmd_ready), 32'd1);
    check("wr_inactive", 32'(dbg_active), 32'd0);
    tick();

    // Read timing: rf_asel in cycle 1, out_valid in cycle 3.
    push_exp(16'hBEEF, 3'd5, 1'b1);
    issue(2'd0, 3'd5, 16'h0000);
    @(negedge clk);
    check("rd_asel", 32'(rf_asel), 32'd5);
    check("rd_valid_c1", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("rd_valid_c2", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("rd_valid_c3", 32'(out_valid), 32'd1);
    tick();
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].exp_out) push_exp(vecs[i].exp_data, vecs[i].rsel, 1'b1);
      issue(vecs[i].op, vecs[i].rsel, vecs[i].data);
      if (vecs[i].op == 2'd3) begin
        @(negedge clk);
        check("rsv_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rsv_rf_wreg", 32'(rf_wreg), 32'd0);
        check("rsv_out_valid", 32'(out_valid), 32'd0);
        tick();
      end
      wait_idle();
    end

    for (int i = 0; i < 8; i++) begin
      issue(2'd1, AW'(i), 16'h1000 + 16'(i));
      wait_idle();
    end

    // Free-flowing dump.
    for (int i = 0; i < 8; i++) push_exp(16'h1000 + 16'(i), AW'(i), i == 7);
    last_xfer = -1;
    chk_spacing = 1'b1;
    issue(2'd2, 3'd0, 16'h0000);
    wait_idle();
    chk_spacing = 1'b0;
    @(negedge clk);
    check("dump_inactive", 32'(dbg_active), 32'd0);
    tick();

    // Dump stalled at index 3 for 10 cycles.
    for (int i = 0; i < 8; i++) push_exp(16'h1000 + 16'(i), AW'(i), i == 7);
    issue(2'd2, 3'd0, 16'h0000);
    wait_out(3'd2, found);
    tick();
    out_ready = 1'b0;
    wait_out(3'd3, found);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h1003);
      check("bp_idx", 32'(out_idx), 32'd3);
      check("bp_asel", 32'(rf_asel), 32'd3);
      tick();
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    wait_idle();

    // Halt gating.
    cpu_halted = 1'b0;
    cmd_op = 2'd1;
    cmd_reg = 3'd1;
    cmd_data = 16'hDEAD;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_cmd_ready", 32'(cmd_ready), 32'd0);
      check("halt_rf_wreg", 32'(rf_wreg), 32'd0);
      check("halt_active", 32'(dbg_active), 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    cpu_halted = 1'b1;
    tick();

    // Halt dropped mid-dump: dump completes, the pending write stays blocked.
    for (int i = 0; i < 8; i++) push_exp(16'h1000 + 16'(i), AW'(i), i == 7);
    issue(2'd2, 3'd0, 16'h0000);
    repeat (4) tick();
    cpu_halted = 1'b0;
    cmd_op = 2'd1;
    cmd_reg = 3'd0;
    cmd_data = 16'h0BAD;
    cmd_valid = 1'b1;
    wait_idle();
    @(negedge clk);
    check("halt_blocked", 32'(cmd_ready), 32'd0);
    tick();
    cmd_valid = 1'b0;
    cpu_halted = 1'b1;
    push_exp(16'h1000, 3'd0, 1'b1);
    issue(2'd0, 3'd0, 16'h0000);
    wait_idle();

    // Reset while in WR.
    issue(2'd1, 3'd2, 16'h5555);
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    check("rstwr_rf_wreg", 32'(rf_wreg), 32'd0);
    check("rstwr_out_valid", 32'(out_valid), 32'd0);
    check("rstwr_active", 32'(dbg_active), 32'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rstwr_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();

    // Reset while in OUT.
    out_ready = 1'b0;
    issue(2'd0, 3'd3, 16'h0000);
    wait_out(3'd3, found);
    tick();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    check("rstout_out_valid", 32'(out_valid), 32'd0);
    check("rstout_rf_wreg", 32'(rf_wreg), 32'd0);
    check("rstout_active", 32'(dbg_active), 32'd0);
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rstout_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();

    push_exp(16'h1003, 3'd3, 1'b1);
    issue(2'd0, 3'd3, 16'h0000);
    wait_idle();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
